// File: rtl/cpu_pkg.sv
// Shared core constants: opcodes, funct3 codes, the ecall word, PC sequencer
// state encoding and the default reset PC.
package cpu_pkg;

  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;

  localparam logic [2:0]  F3_BEQ    = 3'b000;
  localparam logic [2:0]  F3_BNE    = 3'b001;

  localparam logic [31:0] INS_ECALL = 32'h0000_0073;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_BOOT = 2'b00,
    PC_RUN  = 2'b01,
    PC_HALT = 2'b10
  } pc_state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection for one instruction, plus the
// misaligned-taken-target and ecall detect flags.
module pc_next_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] ins,
  input  logic [31:0] pcp4,
  input  logic [31:0] branch,
  input  logic [31:0] jtarget,
  input  logic [31:0] alu_z,
  input  logic        zero,
  output logic [31:0] npc,
  output logic        misaligned,
  output logic        is_ecall
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] br_target;
  logic [31:0] jal_target;
  logic        taken;

  assign opcode     = ins[6:0];
  assign funct3     = ins[14:12];
  // Immediates arrive in halfword units; adds wrap silently mod 2^32.
  assign br_target  = pc + (branch << 1);
  assign jal_target = pc + (jtarget << 1);
  assign is_ecall   = (ins == INS_ECALL);

  always_comb begin
    npc   = pcp4;
    taken = 1'b0;
    case (opcode)
      OP_BRANCH: begin
        if ((funct3 == F3_BEQ && zero) || (funct3 == F3_BNE && !zero)) begin
          npc   = br_target;
          taken = 1'b1;
        end
      end
      OP_JAL: begin
        npc   = jal_target;
        taken = 1'b1;
      end
      OP_JALR: begin
        npc   = alu_z & ~32'h1;
        taken = 1'b1;
      end
      default: begin
        npc   = pcp4;
        taken = 1'b0;
      end
    endcase
  end

  assign misaligned = taken && (npc[1:0] != 2'b00);

endmodule

// File: rtl/pc_sequencer.sv
// PC register and BOOT/RUN/HALT control for the single-cycle core.
// Optional retired-instruction counter is built when PC_RETIRE_COUNT_EN is defined.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] ins,
  input  logic [31:0] pcp4,
  input  logic [31:0] branch,
  input  logic [31:0] jtarget,
  input  logic [31:0] alu_z,
  input  logic        zero,
  output logic [31:0] pc,
  output logic        valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired,
  output pc_state_t   dbg_state
);

  pc_state_t   state_q;
  logic [31:0] pc_q;
  logic        halted_q;
  logic        fault_q;
  logic [31:0] npc;
  logic        misaligned;
  logic        is_ecall;
  logic        advance;

  pc_next_sel u_sel (
    .pc         (pc_q),
    .ins        (ins),
    .pcp4       (pcp4),
    .branch     (branch),
    .jtarget    (jtarget),
    .alu_z      (alu_z),
    .zero       (zero),
    .npc        (npc),
    .misaligned (misaligned),
    .is_ecall   (is_ecall)
  );

  // An instruction completes in any unstalled RUN cycle.
  assign advance = (state_q == PC_RUN) && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= PC_BOOT;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      case (state_q)
        PC_BOOT: state_q <= PC_RUN;
        PC_RUN: begin
          if (!stall) begin
            if (is_ecall) begin
              state_q  <= PC_HALT;
              halted_q <= 1'b1;
            end else if (misaligned) begin
              state_q  <= PC_HALT;
              halted_q <= 1'b1;
              fault_q  <= 1'b1;
            end else begin
              pc_q <= npc;
            end
          end
        end
        PC_HALT: state_q <= PC_HALT;
        default: state_q <= PC_HALT;
      endcase
    end
  end

`ifdef PC_RETIRE_COUNT_EN
  logic [31:0] retired_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      retired_q <= 32'h0;
    end else if (advance && !misaligned) begin
      retired_q <= retired_q + 32'h1;
    end
  end

  assign retired = retired_q;
`else
  assign retired = 32'h0;
`endif

  // valid: the PC is live and downstream writes may commit; high only in RUN.
  assign valid     = (state_q == PC_RUN);
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign fault     = fault_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with RESET_PC = 0x100.
module tb_pc_sequencer;
  import cpu_pkg::*;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] BNE  = 32'h0000_1063;
  localparam logic [31:0] BLT  = 32'h0000_4063;
  localparam logic [31:0] JAL  = 32'h0000_006F;
  localparam logic [31:0] JALR = 32'h0000_0067;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [31:0] ins = NOP;
  logic [31:0] pcp4 = 32'h0;
  logic [31:0] branch = 32'h0;
  logic [31:0] jtarget = 32'h0;
  logic [31:0] alu_z = 32'h0;
  logic        zero = 1'b0;
  logic [31:0] pc;
  logic        valid;
  logic        halted;
  logic        fault;
  logic [31:0] retired;
  pc_state_t   dbg_state;

  int tests = 0;
  int failed = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ins(ins), .pcp4(pcp4),
    .branch(branch), .jtarget(jtarget), .alu_z(alu_z), .zero(zero),
    .pc(pc), .valid(valid), .halted(halted), .fault(fault),
    .retired(retired), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present one instruction fetched at at_pc and advance one edge.
  task automatic run_ins(input logic [31:0] i, input logic [31:0] at_pc);
    ins  = i;
    pcp4 = at_pc + 32'h4;
    step();
  endtask

  task automatic do_reset;
    rst = 1'b1; stall = 1'b0; ins = NOP;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset;
    rst = 1'b1; ins = NOP;
    step();
    tests++; if (pc !== 32'h100) begin failed++; $display("FAIL reset_pc got %h exp %h", pc, 32'h100); end
    tests++; if (valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b exp 0", valid); end
    tests++; if (halted !== 1'b0 || fault !== 1'b0) begin failed++; $display("FAIL reset_flags got %b%b exp 00", halted, fault); end
    tests++; if (retired !== 32'h0) begin failed++; $display("FAIL reset_retired got %h exp 0", retired); end
    rst = 1'b0;
    pcp4 = 32'h104;
    step();
    tests++; if (valid !== 1'b1 || pc !== 32'h100) begin failed++; $display("FAIL boot_run got v=%b pc=%h exp v=1 pc=100", valid, pc); end
    run_ins(NOP, 32'h100);
    tests++; if (pc !== 32'h104) begin failed++; $display("FAIL nop1 got %h exp 104", pc); end
    run_ins(NOP, 32'h104);
    tests++; if (pc !== 32'h108) begin failed++; $display("FAIL nop2 got %h exp 108", pc); end
  endtask

  task automatic test_branch;
    jtarget = 32'hC;
    run_ins(JAL, 32'h108);
    tests++; if (pc !== 32'h120) begin failed++; $display("FAIL jal_to_120 got %h exp 120", pc); end
    branch = 32'hFFFF_FFFC; zero = 1'b1;
    run_ins(BEQ, 32'h120);
    tests++; if (pc !== 32'h118) begin failed++; $display("FAIL beq_taken got %h exp 118", pc); end
    branch = 32'h4; zero = 1'b1;
    run_ins(BEQ, 32'h118);
    tests++; if (pc !== 32'h120) begin failed++; $display("FAIL beq_fwd got %h exp 120", pc); end
    branch = 32'hFFFF_FFFC; zero = 1'b0;
    run_ins(BEQ, 32'h120);
    tests++; if (pc !== 32'h124) begin failed++; $display("FAIL beq_not_taken got %h exp 124", pc); end
    branch = 32'h8; zero = 1'b0;
    run_ins(BNE, 32'h124);
    tests++; if (pc !== 32'h134) begin failed++; $display("FAIL bne_taken got %h exp 134", pc); end
    zero = 1'b1;
    run_ins(BNE, 32'h134);
    tests++; if (pc !== 32'h138) begin failed++; $display("FAIL bne_not_taken got %h exp 138", pc); end
    run_ins(BLT, 32'h138);
    tests++; if (pc !== 32'h13C) begin failed++; $display("FAIL blt_ignored got %h exp 13c", pc); end
    tests++; if (retired !== 32'h0) begin failed++; $display("FAIL retired_tied got %h exp 0", retired); end
  endtask

  task automatic test_jump;
    alu_z = 32'h201;
    run_ins(JALR, 32'h13C);
    tests++; if (pc !== 32'h200) begin failed++; $display("FAIL jalr_200 got %h exp 200", pc); end
    jtarget = 32'h10;
    run_ins(JAL, 32'h200);
    tests++; if (pc !== 32'h220) begin failed++; $display("FAIL jal_220 got %h exp 220", pc); end
    alu_z = 32'h305;
    run_ins(JALR, 32'h220);
    tests++; if (pc !== 32'h304) begin failed++; $display("FAIL jalr_304 got %h exp 304", pc); end
  endtask

  task automatic test_fault;
    alu_z = 32'h306;
    stall = 1'b1;
    run_ins(JALR, 32'h304);
    tests++; if (halted !== 1'b0 || pc !== 32'h304) begin failed++; $display("FAIL fault_stalled got h=%b pc=%h exp h=0 pc=304", halted, pc); end
    stall = 1'b0;
    run_ins(JALR, 32'h304);
    tests++; if (halted !== 1'b1 || fault !== 1'b1) begin failed++; $display("FAIL fault_flags got %b%b exp 11", halted, fault); end
    tests++; if (pc !== 32'h304) begin failed++; $display("FAIL fault_pc got %h exp 304", pc); end
    run_ins(NOP, 32'h304);
    tests++; if (pc !== 32'h304 || valid !== 1'b0 || halted !== 1'b1) begin failed++; $display("FAIL halt_sticky got pc=%h v=%b h=%b exp 304/0/1", pc, valid, halted); end
    rst = 1'b1;
    step();
    tests++; if (pc !== 32'h100 || halted !== 1'b0 || fault !== 1'b0 || valid !== 1'b0) begin failed++; $display("FAIL restart got pc=%h h=%b f=%b v=%b exp 100/0/0/0", pc, halted, fault, valid); end
    rst = 1'b0;
    step();
    branch = 32'h1; zero = 1'b1;
    run_ins(BEQ, 32'h100);
    tests++; if (halted !== 1'b1 || fault !== 1'b1 || pc !== 32'h100) begin failed++; $display("FAIL br_misalign got h=%b f=%b pc=%h exp 1/1/100", halted, fault, pc); end
  endtask

  task automatic test_ecall;
    do_reset();
    alu_z = 32'h40;
    run_ins(JALR, 32'h100);
    tests++; if (pc !== 32'h40) begin failed++; $display("FAIL jalr_40 got %h exp 40", pc); end
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      run_ins(INS_ECALL, 32'h40);
      tests++; if (pc !== 32'h40 || halted !== 1'b0 || valid !== 1'b1) begin failed++; $display("FAIL ecall_stall%0d got pc=%h h=%b v=%b exp 40/0/1", k, pc, halted, valid); end
    end
    stall = 1'b0;
    run_ins(INS_ECALL, 32'h40);
    tests++; if (halted !== 1'b1 || fault !== 1'b0 || pc !== 32'h40) begin failed++; $display("FAIL ecall_halt got h=%b f=%b pc=%h exp 1/0/40", halted, fault, pc); end
    jtarget = 32'h10;
    run_ins(JAL, 32'h40);
    tests++; if (pc !== 32'h40 || valid !== 1'b0) begin failed++; $display("FAIL ecall_frozen got pc=%h v=%b exp 40/0", pc, valid); end
  endtask

  task automatic test_stall_reset;
    do_reset();
    stall = 1'b1;
    run_ins(NOP, 32'h100);
    rst = 1'b1;
    run_ins(NOP, 32'h100);
    tests++; if (valid !== 1'b0 || pc !== 32'h100) begin failed++; $display("FAIL rst_mid_stall got v=%b pc=%h exp 0/100", valid, pc); end
    rst = 1'b0; stall = 1'b0;
    step();
  endtask

`ifdef PC_RETIRE_COUNT_EN
  task automatic test_retire;
    do_reset();
    for (int k = 0; k < 5; k++) run_ins(NOP, 32'h100 + 32'(4 * k));
    stall = 1'b1;
    run_ins(NOP, 32'h114);
    run_ins(NOP, 32'h114);
    stall = 1'b0;
    run_ins(INS_ECALL, 32'h114);
    tests++; if (retired !== 32'd6) begin failed++; $display("FAIL retire_count got %0d exp 6", retired); end
    do_reset();
    force dut.retired_q = 32'hFFFF_FFFF;
    #1;
    release dut.retired_q;
    run_ins(NOP, 32'h100);
    tests++; if (retired !== 32'h0) begin failed++; $display("FAIL retire_wrap got %h exp 0", retired); end
  endtask
`endif

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_fault();
    test_ecall();
    test_stall_reset();
`ifdef PC_RETIRE_COUNT_EN
    test_retire();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter register and next-PC selection for the single-cycle core. Sits directly upstream of the fetch stage: its `pc` output drives the fetch stage's `PCin`. It consumes the fetch stage's `PCp4`, the decode stage's `branch`/`jTarget` immediates and the execute stage's result and zero flag, and selects the next PC. A small state machine handles boot, halt on `ecall` and misaligned-target faults.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset.
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `stall`  in  1: hold PC and state this cycle.
- `ins`  in  32: instruction currently fetched at `pc`.
- `pcp4`  in  32: `pc + 4` from the fetch stage.
- `branch`  in  32: sign-extended SB immediate, halfword units (bit 0 = imm[1]).
- `jtarget`  in  32: sign-extended UJ immediate, halfword units.
- `alu_z`  in  32: execute-stage result (`rs1 + imm` for `jalr`).
- `zero`  in  1: execute-stage zero flag.
- `pc`  out  32: current PC.
- `valid`  out  1: PC is live; downstream writes are enabled only when high.
- `halted`  out  1: core has stopped (ecall or fault).
- `fault`  out  1: stop was caused by a misaligned target.
- `retired`  out  32: retired-instruction count (see Configuration).

## Operation
- States: BOOT, RUN, HALT. Encoding is a package constant.
- Reset: state←BOOT, `pc`←`RESET_PC`, `valid`=0, `halted`=0, `fault`=0, `retired`=0.
- BOOT: `pc` held for one cycle so that the memory read settles. Then BOOT→RUN unconditionally; `stall` is ignored in BOOT.
- RUN, `stall`=1: `pc`, state and counter are held.
- RUN, `stall`=0: the next PC is chosen by the opcode field `ins[6:0]`:
  - `1100011` with funct3 `000` (beq): `pc + (branch<<1)` if `zero`=1, else `pcp4`.
  - `1100011` with funct3 `001` (bne): `pc + (branch<<1)` if `zero`=0, else `pcp4`.
  - `1101111` (jal): `pc + (jtarget<<1)`.
  - `1100111` (jalr): `alu_z & ~32'h1`.
  - `ins` == `32'h0000_0073` (ecall): RUN→HALT, `pc` held, `halted`←1.
  - any other instruction, including other branch funct3 values: `pcp4`.
- Misaligned target: a taken target with `[1:0]`≠0 sends RUN→HALT with `halted`←1 and `fault`←1, and `pc` is held.
- All adds are 32-bit modulo 2^32; wrap-around is silent.
- HALT: sticky until `rst`. `pc` is frozen. `valid`=1 only in RUN.

## Timing
- `pc` is a register. Next-PC selection is combinational from `ins`, `zero` and the immediates in the same cycle, so each instruction takes 1 cycle.
- First RUN cycle is the 2nd rising edge after `rst` deasserts (the BOOT cycle comes first).
- `halted` and `fault` assert on the edge that ends the ecall or faulting cycle.
- `rst` has priority over every other input in every state, including mid-stall and HALT.
- `stall` together with ecall or a fault condition has no effect until `stall`=0.

## Configuration
- `PC_RETIRE_COUNT_EN` defined:
  - `retired` increments on every RUN cycle with `stall`=0 that does not fault; the ecall cycle counts.
  - It wraps `32'hFFFF_FFFF`→0.
- Macro undefined: `retired` is tied to 0 and no counter register exists.

## Structure
- Shared package `cpu_pkg` holds:
  - opcode constants `OP_BRANCH`, `OP_JAL`, `OP_JALR`;
  - funct3 `F3_BEQ`, `F3_BNE`;
  - `INS_ECALL`;
  - state enum `pc_state_t`;
  - default `RESET_PC`.
- One combinational sub-module `pc_next_sel` computes the next PC and the misaligned/ecall flags. The parent holds the state register, PC register and counter.

## Test plan
- Reset with `RESET_PC`=`32'h100`: `pc`=`0x100` and `valid`=0 for one cycle, then `valid`=1 with `pc` still `0x100`. Then a nop stream gives `0x104`, `0x108`.
- beq with `branch`=`32'hFFFF_FFFC`, `zero`=1, at `pc`=`0x120`: next `pc`=`0x118`. Same instruction with `zero`=0: next `pc`=`0x124`.
- jal with `jtarget`=`0x10` at `0x200`: next `pc`=`0x220`. jalr with `alu_z`=`0x305`: next `pc`=`0x304`.
- jalr with `alu_z`=`0x306`: `halted`=`fault`=1 and `pc` is unchanged. `rst` then restarts at `RESET_PC`.
- ecall at `0x40` with `stall`=1 for 3 cycles: `pc` stays `0x40` and no halt occurs. After `stall` drops: `halted`=1, `fault`=0, `pc` frozen.
- With `PC_RETIRE_COUNT_EN`: 5 nops, 2 stall cycles, then ecall gives `retired`=6. Preloading the count to `0xFFFF_FFFF` and retiring one instruction gives 0.
